// File: rtl/mdu_if.sv
// -----------------------------------------------------------------------------
// mdu_if
// Request/result bundle between the core controller and the multiply/divide
// unit.
//   start   : request strobe, sampled on the rising clock edge
//   mdu_op  : 0 mult, 1 multu, 2 div, 3divu, 4 mthi, 5 mtlo, 6/7 reserved
//   a, b    : operands (GRF rs / rt values)
//   busy    : operation in flight
//   hi, lo  : HI / LO architectural registers
// The master modport is the controller side; the slave modport is the MDU.
// -----------------------------------------------------------------------------
interface mdu_if;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdu_op, a, b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, mdu_op, a, b,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu
// Multi-cycle multiply/divide unit producing the HI/LO registers.
// The result is computed at the accept edge and parked in a holding register;
// a down-counter then models the operation latency, and HI/LO are updated on
// the edge where the counter expires.
// Ports:
//   clk    : clock, all state updates on rising edge
//   reset  : asynchronous, active-high; clears HI/LO, busy and counter
//   bus    : mdu_if.slave (start, mdu_op, a, b in; busy, hi, lo out)
// Parameters:
//   MULT_CYCLES : busy duration of mult/multu (>= 1)
//   DIV_CYCLES  : busy duration of div/divu (>= 1)
// -----------------------------------------------------------------------------
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   res_q, res_d;
    logic          commit_q, commit_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic signed [63:0] a_sx, b_sx;
    logic [63:0]        prod_s, prod_u;
    logic               b_zero, div_ovf;
    logic signed [31:0] sa, sb_safe, quo_s, rem_s;
    logic [31:0]        ub_safe, quo_u, rem_u;

    assign a_sx   = {{32{bus.a[31]}}, bus.a};
    assign b_sx   = {{32{bus.b[31]}}, bus.b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

    // The divisor is forced to 1 for divide-by-zero (result discarded anyway)
    // and for 0x80000000 / -1, where dividing by 1 yields exactly the wrapped
    // quotient 0x80000000 with remainder 0 without overflowing the divider.
    assign b_zero  = (bus.b == 32'd0);
    assign div_ovf = (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
    assign sa      = $signed(bus.a);
    assign sb_safe = (b_zero || div_ovf) ? 32'sd1 : $signed(bus.b);
    assign quo_s   = sa / sb_safe;
    assign rem_s   = sa % sb_safe;
    assign ub_safe = b_zero ? 32'd1 : bus.b;
    assign quo_u   = bus.a / ub_safe;
    assign rem_u   = bus.a % ub_safe;

    // Next-state logic: accept requests only while idle; count down while
    // busy and commit the held result when the counter reaches one.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        commit_d = commit_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.mdu_op)
                        3'd0, 3'd1: begin
                            res_d    = (bus.mdu_op == 3'd0) ? prod_s : prod_u;
                            commit_d = 1'b1;
                            cnt_d    = CW'(MULT_CYCLES);
                            state_d  = S_BUSY;
                        end
                        3'd2: begin
                            res_d    = {rem_s, quo_s};
                            commit_d = !b_zero;
                            cnt_d    = CW'(DIV_CYCLES);
                            state_d  = S_BUSY;
                        end
                        3'd3: begin
                            res_d    = {rem_u, quo_u};
                            commit_d = !b_zero;
                            cnt_d    = CW'(DIV_CYCLES);
                            state_d  = S_BUSY;
                        end
                        3'd4:    hi_d = bus.a;
                        3'd5:    lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (commit_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            res_q    <= '0;
            commit_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            commit_q <= commit_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy = (state_q == S_BUSY);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the MIPS core, sitting directly downstream of the datapath register file. It consumes the two GRF read ports (rs, rt values) and produces the HI/LO registers consumed by the mfhi/mflo register-write path. Operations take several cycles and are sequenced by an internal counter. The controller stalls on `busy`.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy duration of mult/multu (≥1)
- `DIV_CYCLES`, 10, busy duration of div/divu (≥1)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `start`  in  1  request; sampled on rising edge of `clk`
- `mdu_op`  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved
- `a`  in  32  operand A (GRF rs value)
- `b`  in  32  operand B (GRF rt value)
- `busy`  out  1  operation in flight; registered
- `hi`  out  32  HI register; registered
- `lo`  out  32  LO register; registered

## Operation
- State: `hi`, `lo`, `busy`, down-counter `cnt` (width ≥ clog2(max(MULT_CYCLES,DIV_CYCLES)+1)), latched op, latched operands or precomputed result.
- Accept: rising edge with `start`=1 and `busy`=0. If `start`=1 and `busy`=1, the request is ignored with no state change.
- mthi/mtlo (op 4/5) accepted: `hi`←`a` / `lo`←`a` at that edge; `busy` stays 0; other register unchanged.
- mult/multu/div/divu accepted: latch op and operands (or compute result into holding register), `cnt`←N (MULT_CYCLES or DIV_CYCLES), `busy`←1.
- Each edge while `busy`=1: `cnt`←`cnt`−1. On the edge where `cnt`=1: commit result to `hi`/`lo`, `busy`←0, `cnt`←0.
- Operand changes after the accept edge do not affect the result.
- mult: signed 32×32→64, {hi,lo}=product. multu: unsigned.
- div: signed; lo=quotient truncated toward zero, hi=remainder with sign of dividend. 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divide by zero (div/divu, b=0): full DIV_CYCLES busy, then `hi`/`lo` unchanged.
- Reserved op 6/7 with `start`=1: ignored, no state change.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, `cnt`=0. Takes effect asynchronously, independent of clock.
- Reset mid-operation aborts the operation with no commit. After reset release, the first edge with `start`=1 is accepted.
- Accept at edge k: `busy`=1 from edge k until edge k+N. At edge k+N, `hi`/`lo` take the result and `busy` falls in the same update. `busy` is high for exactly N cycles.
- `hi`/`lo` hold their old values through the whole busy window. A mfhi/mflo in that window reads stale data; the controller stalls it.
- Back-to-back: earliest next accept is edge k+N+1, i.e. the first edge sampled with `busy`=0.
- mthi/mtlo: zero latency. The new value is visible on `hi`/`lo` immediately after the accept edge.
- Outputs are driven only from flops; no combinational path from inputs to outputs.

## Test plan
- Reset: assert `reset` mid-cycle with no clock edge → `busy`=0, `hi`=`lo`=0 immediately. Start mult, assert `reset` at cycle 2 → no commit, `hi`/`lo` stay 0.
- mult a=0xFFFFFFFF, b=2 → busy exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu same operands → hi=0x00000001, lo=0xFFFFFFFE.
- div a=0xFFFFFFF9 (−7), b=2 → busy exactly 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=100, b=7 → lo=14, hi=2. div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x1234 and lo=0x5678 via mthi/mtlo, then divu a=9, b=0 → busy 10 cycles, then hi=0x1234, lo=0x5678.
- Start while busy: start mult 3×4, then at cycle 2 pulse mtlo a=0xDEAD and start div 8/2 → both ignored. Final hi=0, lo=12. Alter `a`/`b` during busy → result unchanged.
- Back-to-back: mult 3×4, then start divu 12/5 on the first edge with `busy`=0 → hi=0, lo=12 after 5 cycles. Next request accepted at the following edge; after 10 more cycles lo=2, hi=2. mthi a=0xABCD with `busy`=0 → hi=0xABCD next cycle, `busy` stays 0.
